xcvr_prbs_checker: RTL and testbench

XCVR_PRBS_CHECKER -- requirements
Module: xcvr_prbs_checker

---
 rtl/xcvr_prbs_checker.sv | 94 +++++++++
 tb/tb_xcvr_prbs_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/xcvr_prbs_checker.sv
// xcvr_prbs_checker: self-synchronous PRBS31 receive checker with lock FSM and saturating error/word counters
module xcvr_prbs_checker #(
    parameter int DATAWIDTH  = 40,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                 rx_clkout,
    input  logic                 test_reset_n,
    input  logic [DATAWIDTH-1:0] rx_data,
    input  logic                 chk_en,
    input  logic                 clear,
    output logic                 locked,
    output logic [6:0]           word_errs,
    output logic [31:0]          err_count,
    output logic [47:0]          word_count,
    output logic                 err_sticky
);
    localparam int RMAX = LOCK_CNT > UNLOCK_CNT ? LOCK_CNT : UNLOCK_CNT;
    localparam int RW   = $clog2(RMAX + 1);
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t                 state_q, state_d;
    logic [30:0]            hist_q, hist_d;
    logic                   hist_valid_q, hist_valid_d;
    logic                   chk_v_q, chk_v_d;
    logic                   err_sticky_q, err_sticky_d;
    logic [RW-1:0]          run_q, run_d, run_inc, run_lim;
    logic [6:0]             word_errs_q, word_errs_d;
    logic [31:0]            err_count_q, err_count_d;
    logic [47:0]            word_count_q, word_count_d;
    logic [DATAWIDTH+30:0]  ext;
    logic [DATAWIDTH-1:0]   mism;
    logic [32:0]            err_sum;
    logic                   acc, hit;
    always_comb begin
        // ext[31+k] is received bit k of this word; ext[30:0] are the 31 preceding bits
        ext          = {rx_data, hist_q};
        mism         = '0;
        for (int i = 0; i < DATAWIDTH; i++) mism[i] = ext[31+i] ^ ext[i] ^ ext[i+3];
        chk_v_d      = chk_en & hist_valid_q;
        hist_d       = chk_en ? ext[DATAWIDTH+30:DATAWIDTH] : hist_q;
        hist_valid_d = hist_valid_q | chk_en;
        word_errs_d  = word_errs_q;
        if (chk_v_d) begin
            word_errs_d = '0;
            for (int i = 0; i < DATAWIDTH; i++) word_errs_d = word_errs_d + {6'b0, mism[i]};
            if (rx_data == '0) word_errs_d = 7'(DATAWIDTH);
        end
        hit     = (state_q == HUNT) ? (word_errs_q == '0) : (word_errs_q != '0);
        run_lim = (state_q == HUNT) ? RW'(LOCK_CNT) : RW'(UNLOCK_CNT);
        run_inc = run_q + 1'b1;
        state_d = state_q;
        run_d   = run_q;
        if (chk_v_q) begin
            run_d = hit ? run_inc : '0;
            if (hit && run_inc == run_lim) begin
                state_d = (state_q == HUNT) ? LOCKED : HUNT;
                run_d   = '0;
            end
        end
        acc          = chk_v_q & (state_q == LOCKED);
        err_sum      = {1'b0, err_count_q} + {26'b0, word_errs_q};
        err_count_d  = clear ? '0 : !acc ? err_count_q : err_sum[32] ? '1 : err_sum[31:0];
        word_count_d = clear ? '0 : (acc && !(&word_count_q)) ? word_count_q + 48'd1 : word_count_q;
        err_sticky_d = !clear & (err_sticky_q | (acc & (word_errs_q != '0)));
    end
    always_ff @(posedge rx_clkout or negedge test_reset_n) begin
        if (!test_reset_n) begin
            state_q      <= HUNT;
            hist_q       <= '0;
            hist_valid_q <= 1'b0;
            chk_v_q      <= 1'b0;
            run_q        <= '0;
            word_errs_q  <= '0;
            err_count_q  <= '0;
            word_count_q <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            hist_valid_q <= hist_valid_d;
            chk_v_q      <= chk_v_d;
            run_q        <= run_d;
            word_errs_q  <= word_errs_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
            err_sticky_q <= err_sticky_d;
        end
    end
    assign locked     = state_q == LOCKED;
    assign word_errs  = word_errs_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;
    assign err_sticky = err_sticky_q;
endmodule

// File: tb/tb_xcvr_prbs_checker.sv
// tb_xcvr_prbs_checker: random PRBS31 stimulus checked against a bit-stream reference model
module tb_xcvr_prbs_checker;
    localparam int DW = 40;
    localparam int LK = 16;
    localparam int UL = 4;
    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] rx_data;
    logic          chk_en, clear;
    logic          locked, err_sticky;
    logic [6:0]    word_errs;
    logic [31:0]   err_count;
    logic [47:0]   word_count;
    int            n_vec = 0, n_err = 0;
    bit            g[$];
    bit            s[$];
    bit            m_hv, m_locked, m_sticky, p_v;
    int            m_errs, p_e, m_run;
    longint unsigned m_err, m_wc;
    logic [DW-1:0] w;
    xcvr_prbs_checker #(.DATAWIDTH(DW), .LOCK_CNT(LK), .UNLOCK_CNT(UL)) dut (
        .rx_clkout(clk), .test_reset_n(rst_n), .rx_data(rx_data), .chk_en(chk_en),
        .clear(clear), .locked(locked), .word_errs(word_errs), .err_count(err_count),
        .word_count(word_count), .err_sticky(err_sticky)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic check_all();
        check("locked", 64'(locked), 64'(m_locked));
        check("word_errs", 64'(word_errs), 64'(m_errs));
        check("err_count", 64'(err_count), m_err);
        check("word_count", 64'(word_count), m_wc);
        check("err_sticky", 64'(err_sticky), 64'(m_sticky));
    endtask
    task automatic gen_word(output logic [DW-1:0] o);
        for (int k = 0; k < DW; k++) begin
            bit b;
            b = g[g.size()-31] ^ g[g.size()-28];
            g.push_back(b);
            o[k] = b;
        end
        while (g.size() > 64) void'(g.pop_front());
    endtask
    task automatic model_reset();
        s.delete();
        m_hv = 0; m_locked = 0; m_sticky = 0; p_v = 0;
        m_errs = 0; p_e = 0; m_run = 0; m_err = 0; m_wc = 0;
    endtask
    task automatic model_edge(input logic [DW-1:0] d, input bit en, input bit clr);
        int errs;
        if (clr) begin
            m_err = 0; m_wc = 0; m_sticky = 0;
        end else if (p_v && m_locked) begin
            m_err = (m_err + p_e > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_err + p_e;
            if (m_wc != 64'hFFFF_FFFF_FFFF) m_wc++;
            if (p_e != 0) m_sticky = 1;
        end
        if (p_v) begin
            if (!m_locked) begin
                m_run = (p_e == 0) ? m_run + 1 : 0;
                if (m_run == LK) begin m_locked = 1; m_run = 0; end
            end else begin
                m_run = (p_e != 0) ? m_run + 1 : 0;
                if (m_run == UL) begin m_locked = 0; m_run = 0; end
            end
        end
        p_v = 0;
        if (en) begin
            errs = 0;
            for (int k = 0; k < DW; k++) begin
                if (m_hv && (s[s.size()-31] ^ s[s.size()-28]) != d[k]) errs++;
                s.push_back(d[k]);
            end
            while (s.size() > 64) void'(s.pop_front());
            if (d == '0) errs = DW;
            if (m_hv) begin p_v = 1; p_e = errs; m_errs = errs; end
            m_hv = 1;
        end
    endtask
    task automatic step(input logic [DW-1:0] d, input bit en, input bit clr);
        rx_data = d; chk_en = en; clear = clr;
        @(posedge clk);
        model_edge(d, en, clr);
        #1;
        check_all();
    endtask
    task automatic clean(input int n);
        for (int i = 0; i < n; i++) begin gen_word(w); step(w, 1, 0); end
    endtask
    task automatic pulse_reset();
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk) rst_n = 1;
    endtask
    initial begin
        rst_n = 0; rx_data = '0; chk_en = 0; clear = 0;
        for (int i = 0; i < 31; i++) g.push_back(bit'($urandom_range(0, 1)));
        g[0] = 1;
        model_reset();
        #1 check_all();
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 25; i++) begin
            gen_word(w); step(w, 1, 0);
            if (i == 16) check("lock_early", 64'(locked), 64'd0);
            if (i == 17) check("lock_on", 64'(locked), 64'd1);
        end
        for (int i = 0; i < 80; i++) begin
            bit en;
            en = ($urandom_range(0, 9) < 7);
            if (en) begin
                gen_word(w);
                if ($urandom_range(0, 7) == 0) w[$urandom_range(0, DW-1)] ^= 1'b1;
            end else w = DW'({$urandom, $urandom});
            step(w, en, $urandom_range(0, 19) == 0);
        end
        clean(5);
        for (int i = 0; i < 4; i++) step('0, 1, 0);
        step(w, 0, 0);
        check("unlock", 64'(locked), 64'd0);
        clean(30);
        check("relock", 64'(locked), 64'd1);
        #1;
        force dut.err_count_q = 32'hFFFF_FFF0;
        force dut.word_count_q = 48'hFFFF_FFFF_FFFD;
        #1;
        release dut.err_count_q;
        release dut.word_count_q;
        m_err = 64'hFFFF_FFF0; m_wc = 64'hFFFF_FFFF_FFFD;
        for (int i = 0; i < 4; i++) step('0, 1, 0);
        step(w, 0, 0);
        check("err_sat", 64'(err_count), 64'hFFFF_FFFF);
        check("wc_sat", 64'(word_count), 64'hFFFF_FFFF_FFFF);
        clean(30);
        gen_word(w); w[$urandom_range(0, DW-1)] ^= 1'b1;
        step(w, 1, 0);
        gen_word(w); step(w, 1, 1);
        check("clr_err", 64'(err_count), 64'd0);
        check("clr_sticky", 64'(err_sticky), 64'd0);
        check("clr_lock", 64'(locked), 64'd1);
        clean(3);
        pulse_reset();
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin gen_word(w); step(w, 1, 0); end
            else step(DW'({$urandom, $urandom}), 0, 0);
        end
        check("toggle_lock", 64'(locked), 64'd1);
        pulse_reset();
        clean(19);
        check("relock_rst", 64'(locked), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
